// File: rtl/board_io_pkg.sv
// board_io_pkg
//   Shared constants for the board I/O controller: bus data width,
//   register word addresses and a width-legality helper used at
//   elaboration time by board_io_ctrl.
package board_io_pkg;

   localparam int BUS_DW = 32;
   localparam int ADDR_W = 4;

   localparam logic [ADDR_W-1:0] ADDR_PB_STATE  = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_SW_STATE  = 4'h1;
   localparam logic [ADDR_W-1:0] ADDR_PB_EDGE   = 4'h2;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_EN    = 4'h3;
   localparam logic [ADDR_W-1:0] ADDR_LED       = 4'h4;
   localparam logic [ADDR_W-1:0] ADDR_LED_BLINK = 4'h5;

   // A vector width is legal when it fits in one bus word.
   function automatic bit width_ok(input int w);
      return (w >= 1) && (w <= BUS_DW);
   endfunction

endpackage

// File: rtl/board_io_debounce.sv
// board_io_debounce
//   Synchroniser plus per-bit debounce counters for a vector of slow,
//   asynchronous board inputs.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset (clears sync flops, counters, state)
//   din_i    raw asynchronous inputs
//   state_o  debounced state, changes SYNC_STAGES+DEBOUNCE_CYCLES cycles after
//            a stable input change
module board_io_debounce
   import board_io_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] state_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // The flip happens on the edge where the count would reach
   // DEBOUNCE_CYCLES, i.e. while the register still holds DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      for (int b = 0; b < WIDTH; b++) begin
         cnt_d[b] = cnt_q[b];
         if (synced[b] == state_q[b]) begin
            cnt_d[b] = '0;
         end else if (cnt_q[b] == CNT_LAST) begin
            state_d[b] = synced[b];
            cnt_d[b]   = '0;
         end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
         state_q <= '0;
      end else begin
         sync_q[0] <= din_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
//   Board I/O controller: debounced push-buttons and switches, sticky
//   push-button rising-edge bits with interrupt, LED register with optional
//   per-LED blink, all behind a single-outstanding register bus.
//   Optional feature macro: BOARD_IO_BLINK_EN (blink prescaler + LED_BLINK).
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   pll_locked_i         PLL lock (async); block held in reset while low
//   pb_i, sw_i           raw push-buttons (1 = pressed) and switches
//   led_o                registered LED drive
//   req_*                bus request: valid/ready/we/addr/wdata
//   rsp_valid_o/rdata_o  one-cycle response, rdata 0 for writes
//   irq_o                registered level interrupt |(PB_EDGE & IRQ_EN)
//
// Bus handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; req_ready_o is 1 whenever out of reset, so every
// request transfers in one cycle. Exactly one cycle later rsp_valid_o pulses
// for one cycle with rsp_rdata_o valid. Writes update registers on the
// transferring edge.
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NUM_PB          = 4,
   parameter int NUM_SW          = 8,
   parameter int NUM_LED         = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pll_locked_i,
   input  logic [NUM_PB-1:0]  pb_i,
   input  logic [NUM_SW-1:0]  sw_i,
   output logic [NUM_LED-1:0] led_o,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [ADDR_W-1:0]  req_addr_i,
   input  logic [BUS_DW-1:0]  req_wdata_i,
   output logic               rsp_valid_o,
   output logic [BUS_DW-1:0]  rsp_rdata_o,
   output logic               irq_o
);

   if (!width_ok(NUM_PB) || !width_ok(NUM_SW) || !width_ok(NUM_LED)) begin : g_bad_width
      $error("board_io_ctrl: NUM_PB, NUM_SW and NUM_LED must be in 1..32");
   end
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
      $error("board_io_ctrl: SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1, BLINK_CYCLES >= 1");
   end

   // Lock is synchronised here; loss of lock behaves exactly like rst_i.
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   int_rst;

   always_ff @(posedge clk_i) begin
      if (rst_i) lock_sync_q <= '0;
      else       lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
   end

   assign int_rst = rst_i | ~lock_sync_q[SYNC_STAGES-1];

   logic [NUM_PB-1:0] pb_db;
   logic [NUM_SW-1:0] sw_db;

   board_io_debounce #(.WIDTH(NUM_PB), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_pb_db (.clk_i(clk_i), .rst_i(int_rst), .din_i(pb_i), .state_o(pb_db));

   board_io_debounce #(.WIDTH(NUM_SW), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_sw_db (.clk_i(clk_i), .rst_i(int_rst), .din_i(sw_i), .state_o(sw_db));

   logic [NUM_PB-1:0]  pb_prev_q, pb_edge_q, pb_edge_d, irq_en_q, irq_en_d;
   logic [NUM_LED-1:0] led_q, led_d, led_out_q, led_drive;
   logic               ready_q, rsp_valid_q, irq_q;
   logic [BUS_DW-1:0]  rsp_rdata_q, rdata_d;
   logic               req_fire, wr_en;
   logic               unused_wdata;

   assign req_fire = req_valid_i & ready_q;
   assign wr_en    = req_fire & req_we_i;
   // Field widths are at most 32, so upper write-data bits may be dropped.
   assign unused_wdata = ^req_wdata_i;

`ifdef BOARD_IO_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   logic [BLINK_W-1:0] blink_cnt_q;
   logic               phase_q;
   logic [NUM_LED-1:0] led_blink_q;

   always_ff @(posedge clk_i) begin
      if (int_rst) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         led_blink_q <= '0;
      end else begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
         if (wr_en && req_addr_i == ADDR_LED_BLINK) led_blink_q <= req_wdata_i[NUM_LED-1:0];
      end
   end

   // A blinking LED is only lit during the high half of the phase.
   assign led_drive = led_q & (~led_blink_q | {NUM_LED{phase_q}});
`else
   assign led_drive = led_q;
`endif

   always_comb begin
      // A W1C clear and a fresh rising edge on the same bit: the edge wins.
      pb_edge_d = pb_edge_q | (pb_db & ~pb_prev_q);
      if (wr_en && req_addr_i == ADDR_PB_EDGE)
         pb_edge_d = (pb_edge_q & ~req_wdata_i[NUM_PB-1:0]) | (pb_db & ~pb_prev_q);

      irq_en_d = irq_en_q;
      if (wr_en && req_addr_i == ADDR_IRQ_EN) irq_en_d = req_wdata_i[NUM_PB-1:0];

      led_d = led_q;
      if (wr_en && req_addr_i == ADDR_LED) led_d = req_wdata_i[NUM_LED-1:0];

      rdata_d = '0;
      if (req_fire && !req_we_i) begin
         case (req_addr_i)
            ADDR_PB_STATE:  rdata_d[NUM_PB-1:0]  = pb_db;
            ADDR_SW_STATE:  rdata_d[NUM_SW-1:0]  = sw_db;
            ADDR_PB_EDGE:   rdata_d[NUM_PB-1:0]  = pb_edge_q;
            ADDR_IRQ_EN:    rdata_d[NUM_PB-1:0]  = irq_en_q;
            ADDR_LED:       rdata_d[NUM_LED-1:0] = led_q;
`ifdef BOARD_IO_BLINK_EN
            ADDR_LED_BLINK: rdata_d[NUM_LED-1:0] = led_blink_q;
`endif
            default:        rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (int_rst) begin
         pb_prev_q   <= '0;
         pb_edge_q   <= '0;
         irq_en_q    <= '0;
         led_q       <= '0;
         led_out_q   <= '0;
         irq_q       <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         pb_prev_q   <= pb_db;
         pb_edge_q   <= pb_edge_d;
         irq_en_q    <= irq_en_d;
         led_q       <= led_d;
         led_out_q   <= led_drive;
         irq_q       <= |(pb_edge_q & irq_en_q);
         ready_q     <= 1'b1;
         rsp_valid_q <= req_fire;
         rsp_rdata_q <= rdata_d;
      end
   end

   assign led_o       = led_out_q;
   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign irq_o       = irq_q;

endmodule
